// File: rtl/ps2_pkg.sv
// Shared types and frame geometry for the PS/2 receive framer.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } ps2_state_t;

    // Start + data + parity + stop.
    function automatic int ps2_frame_len(input int data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word fall-through receive FIFO; a wrap bit on each pointer separates full from empty.
module ps2_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_data,
    output logic              o_empty,
    output logic              o_full
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_do_wr;
    logic              w_do_rd;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    // A pop frees the slot, so a write alongside a pop is allowed even when full.
    assign w_do_rd = i_rd_en && !o_empty;
    assign w_do_wr = i_wr_en && (!o_full || w_do_rd);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/ps2_rx_framer.sv
// PS/2 device-to-host frame receiver: synchroniser, framing FSM with timeout, receive FIFO.
// Build option: define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_rx_framer
    import ps2_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              full,
    output logic              frame_err,
    output logic              overflow,
    output logic              busy
);

    localparam int SHIFT_BITS = ps2_frame_len(DATA_W) - 1;
    localparam int CW         = $clog2(SHIFT_BITS + 1);
    localparam int TW         = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(SHIFT_BITS - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic                   w_fall;
    logic                   w_bit;

    ps2_state_t             r_state, w_state_nxt;
    logic [CW-1:0]          r_bit_cnt, w_bit_cnt_nxt;
    logic [TW-1:0]          r_to_cnt, w_to_cnt_nxt;
    logic [SHIFT_BITS-1:0]  r_shift, w_shift_nxt;
    logic                   r_frame_err, w_ferr_nxt;
    logic                   r_overflow, w_ovf_nxt;
    logic                   w_push;
    logic                   w_frame_bad;

    // Idle-high lines: presetting to 1 keeps reset release from looking like a fall.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_fall = r_clk_prev && !r_clk_sync[SYNC_STAGES-1];
    assign w_bit  = r_data_sync[SYNC_STAGES-1];

    // r_shift holds {stop, parity, data} with the first data bit at the LSB.
`ifdef PS2_PARITY_CHECK_EN
    assign w_frame_bad = !r_shift[SHIFT_BITS-1] || !(^r_shift[DATA_W:0]);
`else
    assign w_frame_bad = !r_shift[SHIFT_BITS-1];
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        w_shift_nxt   = r_shift;
        w_ferr_nxt    = 1'b0;
        w_ovf_nxt     = 1'b0;
        w_push        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall && !w_bit) begin
                    w_state_nxt   = SHIFT;
                    w_bit_cnt_nxt = '0;
                    w_to_cnt_nxt  = '0;
                end
            end
            SHIFT: begin
                if (w_fall) begin
                    w_shift_nxt   = {w_bit, r_shift[SHIFT_BITS-1:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                    w_to_cnt_nxt  = '0;
                    if (r_bit_cnt == LAST_BIT) w_state_nxt = CHECK;
                end else if (r_to_cnt == TO_LAST) begin
                    w_ferr_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
            end
            CHECK: begin
                w_state_nxt = IDLE;
                if (w_frame_bad)         w_ferr_nxt = 1'b1;
                else if (full && !rd_en) w_ovf_nxt  = 1'b1;
                else                     w_push     = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_to_cnt    <= '0;
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_frame_err <= w_ferr_nxt;
            r_overflow  <= w_ovf_nxt;
        end
    end

    always_ff @(posedge sys_clk) begin
        r_shift <= w_shift_nxt;
    end

    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;
    assign busy      = (r_state != IDLE);

    ps2_rx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .i_wr_en   (w_push),
        .i_wr_data (r_shift[DATA_W-1:0]),
        .i_rd_en   (rd_en),
        .o_data    (data_out),
        .o_empty   (empty),
        .o_full    (full)
    );

endmodule

// File: tb/tb_ps2_rx_framer.sv
// Scoreboard bench for ps2_rx_framer: frame-level reference model feeds an expected-data queue.
module tb_ps2_rx_framer;

    localparam int DATA_W      = 8;
    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT_CYC = 200;
    localparam int FL          = DATA_W + 3;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic              sys_clk  = 1'b0;
    logic              reset    = 1'b1;
    logic              ps2_clk  = 1'b1;
    logic              ps2_data = 1'b1;
    logic              rd_en    = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              empty, full, frame_err, overflow, busy;

    int total = 0;
    int bad   = 0;
    int exp_ferr = 0, exp_ovf = 0;
    int obs_ferr = 0, obs_ovf = 0;
    bit reading = 1'b0;
    logic [DATA_W-1:0] exp_q[$];

    ps2_rx_framer #(
        .DATA_W      (DATA_W),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .empty     (empty),
        .full      (full),
        .frame_err (frame_err),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame as transmitted, LSB first: start 0, data, odd parity, stop 1.
    function automatic logic [FL-1:0] frame_bits(input logic [DATA_W-1:0] d,
                                                 input bit bad_par, input bit bad_stop);
        logic par;
        par = ~(^d) ^ bad_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [FL-1:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sys_clk);
            ps2_data = bits[i];
            repeat (4) @(negedge sys_clk);
            ps2_clk = 1'b0;
            repeat (8) @(negedge sys_clk);
            ps2_clk = 1'b1;
            repeat (3) @(negedge sys_clk);
        end
    endtask

    // Reference outcome of one whole frame, decided from the occupancy the bench expects.
    task automatic expect_frame(input logic [DATA_W-1:0] d, input bit bad_par, input bit bad_stop);
        if (bad_stop || (PAR_EN && bad_par)) exp_ferr++;
        else if (exp_q.size() >= FIFO_DEPTH) exp_ovf++;
        else exp_q.push_back(d);
    endtask

    task automatic frame(input logic [DATA_W-1:0] d, input bit bad_par, input bit bad_stop);
        expect_frame(d, bad_par, bad_stop);
        send_bits(frame_bits(d, bad_par, bad_stop), FL);
        repeat (12) @(negedge sys_clk);
    endtask

    // Monitor: counts pulses and pops/compares the FIFO head whenever reading is enabled.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (frame_err) obs_ferr++;
            if (overflow)  obs_ovf++;
            if (frame_err || overflow) check("err_exclusive", int'(frame_err && overflow), 0);
            if (reading && !empty) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got 0x%0h, expected no data", data_out);
                end else begin
                    check("pop_data", int'(data_out), int'(exp_q.pop_front()));
                end
                rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] rd;
        logic [FL-1:0]     spur;

        repeat (4) @(negedge sys_clk);
        check("rst_data_out", int'(data_out), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (6) @(negedge sys_clk);
        check("post_rst_busy", int'(busy), 0);

        // Single good frame held in FIFO, then popped.
        reading = 1'b0;
        frame(8'h1C, 1'b0, 1'b0);
        check("push_empty", int'(empty), 0);
        check("push_data_out", int'(data_out), 8'h1C);
        reading = 1'b1;
        repeat (4) @(negedge sys_clk);
        reading = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("pop_empty", int'(empty), 1);

        // Wrong parity: rejected only when parity checking is built in.
        frame(8'h1C, 1'b1, 1'b0);
        check("par_empty", int'(empty), PAR_EN ? 1 : 0);
        reading = 1'b1;
        repeat (4) @(negedge sys_clk);

        // Stop bit 0.
        frame(8'h1C, 1'b0, 1'b1);
        check("stop_empty", int'(empty), 1);
        check("ferr_cnt_a", obs_ferr, exp_ferr);

        // Truncated frame then silence: timeout.
        exp_ferr++;
        send_bits(frame_bits(8'hA5, 1'b0, 1'b0), 5);
        repeat (TIMEOUT_CYC + 20) @(negedge sys_clk);
        check("timeout_busy", int'(busy), 0);
        check("ferr_cnt_b", obs_ferr, exp_ferr);
        frame(8'hF0, 1'b0, 1'b0);
        check("after_timeout_empty", int'(empty), 1);

        // Fill, overflow, drain.
        reading = 1'b0;
        for (int i = 0; i < 4; i++) frame(8'(8'h11 + i), 1'b0, 1'b0);
        check("fill_full", int'(full), 1);
        check("fill_ovf_cnt", obs_ovf, 0);
        frame(8'h15, 1'b0, 1'b0);
        check("ovf_cnt", obs_ovf, exp_ovf);
        check("ovf_head", int'(data_out), 8'h11);
        check("ovf_still_full", int'(full), 1);
        reading = 1'b1;
        repeat (12) @(negedge sys_clk);
        check("drain_empty", int'(empty), 1);

        // Reset in the middle of a frame with one entry buffered.
        reading = 1'b0;
        frame(8'h33, 1'b0, 1'b0);
        check("pre_rst_empty", int'(empty), 0);
        send_bits(frame_bits(8'h5A, 1'b0, 1'b0), 5);
        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge sys_clk);
        check("mid_rst_data_out", int'(data_out), 0);
        check("mid_rst_empty", int'(empty), 1);
        check("mid_rst_full", int'(full), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_frame_err", int'(frame_err), 0);
        check("mid_rst_overflow", int'(overflow), 0);
        reset = 1'b0;
        repeat (4) @(negedge sys_clk);
        reading = 1'b1;
        frame(8'h5A, 1'b0, 1'b0);
        check("ferr_cnt_c", obs_ferr, exp_ferr);

        // Randomised frames with occasional spurious idle edges.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                spur = '1;
                send_bits(spur, 1);
                repeat (6) @(negedge sys_clk);
            end
            rd = 8'($urandom);
            frame(rd, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end

        repeat (20) @(negedge sys_clk);
        check("final_ferr_cnt", obs_ferr, exp_ferr);
        check("final_ovf_cnt", obs_ovf, exp_ovf);
        check("final_leftover", exp_q.size(), 0);
        check("final_empty", int'(empty), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
